counter_seq_ctrl: RTL and testbench

- Sequencer that drives an external univ_bin_counter through its syn_clr/load/en/up/d controls and monitors its q/max_tick/min_tick.
- On a start request it runs a programmed number of count sweeps from a start value to a stop value: up-only, down-only, or ping-pong.
- It supports pause and abort, and reports busy/done/wrap status to a host FSM or register block.

---
 rtl/counter_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Sequencer for an external univ_bin_counter. On a start request it loads the
// counter with start_val and runs a programmed number of sweeps towards
// stop_val: up-only, down-only, or ping-pong (alternating direction without
// reload). Supports pause (freezes the counter in RUN) and abort (returns to
// IDLE and synchronously clears the counter for one cycle).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   start, abort, pause      host controls
//   mode                     00 up, 01 down, 10 ping-pong, 11 treated as 00
//   start_val, stop_val      sweep end points
//   sweeps                   number of sweeps (0 treated as 1)
//   cnt_q, cnt_max_tick,
//   cnt_min_tick             counter status inputs
//   cnt_syn_clr, cnt_load,
//   cnt_en, cnt_up, cnt_d    counter control outputs
//   busy, done, sweep_idx,
//   wrapped                  status to the host
module counter_seq_ctrl #(
   parameter int N  = 3,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          pause,
   input  logic [1:0]    mode,
   input  logic [N-1:0]  start_val,
   input  logic [N-1:0]  stop_val,
   input  logic [CW-1:0] sweeps,
   input  logic [N-1:0]  cnt_q,
   input  logic          cnt_max_tick,
   input  logic          cnt_min_tick,
   output logic          cnt_syn_clr,
   output logic          cnt_load,
   output logic          cnt_en,
   output logic          cnt_up,
   output logic [N-1:0]  cnt_d,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] sweep_idx,
   output logic          wrapped
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_TURN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // Run parameters captured at start so host inputs may change mid-run.
   logic [1:0]    mode_r;
   logic [N-1:0]  start_r;
   logic [N-1:0]  stop_r;
   logic [CW-1:0] sweeps_r;
   logic [N-1:0]  tgt;        // end point of the sweep in progress
   logic          dir;        // 1 = counting up
   logic          clr_pend;   // IDLE cycle that follows an abort

   logic run_en;
   logic sweep_end;
   logic last_sweep;
   logic wrap_evt;

   // Count enable is combinational on cnt_q so the counter stops exactly on tgt.
   assign run_en     = (state == S_RUN) && !pause && (cnt_q != tgt);
   assign sweep_end  = (state == S_RUN) && !pause && (cnt_q == tgt);
   assign last_sweep = (sweep_idx == sweeps_r - CW'(1));
   // A step taken from max upwards or from 0 downwards wraps modulo 2^N.
   assign wrap_evt   = run_en && (dir ? cnt_max_tick : cnt_min_tick);

   // State register
   // NOTE: sequential state uses non-blocking assignments; the async reset
   // clears it immediately, independent of clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; abort overrides every transition outside IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_RUN;
         S_RUN:  if (sweep_end) state_nxt = last_sweep ? S_DONE : S_TURN;
         S_TURN: state_nxt = (mode_r == 2'b10) ? S_RUN : S_LOAD;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
   end

   // Run parameters, sweep bookkeeping and sticky wrap flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_r    <= 2'b00;
         start_r   <= '0;
         stop_r    <= '0;
         sweeps_r  <= '0;
         tgt       <= '0;
         dir       <= 1'b0;
         clr_pend  <= 1'b0;
         sweep_idx <= '0;
         wrapped   <= 1'b0;
      end else begin
         clr_pend <= abort && (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_r    <= (mode == 2'b11) ? 2'b00 : mode;
                  start_r   <= start_val;
                  stop_r    <= stop_val;
                  sweeps_r  <= (sweeps == '0) ? CW'(1) : sweeps;
                  tgt       <= stop_val;
                  dir       <= (mode != 2'b01);
                  sweep_idx <= '0;
                  wrapped   <= 1'b0;
               end
            end
            S_RUN: begin
               if (wrap_evt) wrapped <= 1'b1;
            end
            S_TURN: begin
               if (!abort) begin
                  sweep_idx <= sweep_idx + CW'(1);
                  if (mode_r == 2'b10) begin
                     // Ping-pong: reverse and head back to the other end point.
                     dir <= ~dir;
                     tgt <= dir ? start_r : stop_r;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      cnt_syn_clr = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      cnt_up      = 1'b0;
      cnt_d       = '0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            busy        = 1'b0;
            cnt_syn_clr = clr_pend;
         end
         S_LOAD: begin
            cnt_load = 1'b1;
            cnt_d    = start_r;
            cnt_up   = dir;
         end
         S_RUN: begin
            cnt_up = dir;
            cnt_en = run_en;
         end
         S_TURN: cnt_up = dir;
         S_DONE: begin
            cnt_up = dir;
            done   = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl
// Self-checking bench for counter_seq_ctrl. A behavioural univ_bin_counter is
// attached to the sequencer; each directed step pushes the hand-derived
// expected outputs for that cycle and pops/compares them once sampled.
module tb_counter_seq_ctrl;

   localparam int N  = 3;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic          pause;
   logic [1:0]    mode;
   logic [N-1:0]  start_val;
   logic [N-1:0]  stop_val;
   logic [CW-1:0] sweeps;
   logic [N-1:0]  cnt_q;
   logic          cnt_max_tick;
   logic          cnt_min_tick;
   logic          cnt_syn_clr;
   logic          cnt_load;
   logic          cnt_en;
   logic          cnt_up;
   logic [N-1:0]  cnt_d;
   logic          busy;
   logic          done;
   logic [CW-1:0] sweep_idx;
   logic          wrapped;

   typedef struct packed {
      logic          clr;
      logic          ld;
      logic          en;
      logic          up;
      logic          busy;
      logic          done;
      logic          wr;
      logic [N-1:0]  d;
      logic [N-1:0]  q;
      logic [CW-1:0] idx;
   } obs_t;

   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   counter_seq_ctrl #(.N(N), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .pause        (pause),
      .mode         (mode),
      .start_val    (start_val),
      .stop_val     (stop_val),
      .sweeps       (sweeps),
      .cnt_q        (cnt_q),
      .cnt_max_tick (cnt_max_tick),
      .cnt_min_tick (cnt_min_tick),
      .cnt_syn_clr  (cnt_syn_clr),
      .cnt_load     (cnt_load),
      .cnt_en       (cnt_en),
      .cnt_up       (cnt_up),
      .cnt_d        (cnt_d),
      .busy         (busy),
      .done         (done),
      .sweep_idx    (sweep_idx),
      .wrapped      (wrapped)
   );

   // Behavioural univ_bin_counter sharing the system reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 cnt_q <= '0;
      else if (cnt_syn_clr)     cnt_q <= '0;
      else if (cnt_load)        cnt_q <= cnt_d;
      else if (cnt_en && cnt_up) cnt_q <= cnt_q + N'(1);
      else if (cnt_en)          cnt_q <= cnt_q - N'(1);
   end
   assign cnt_max_tick = (cnt_q == {N{1'b1}});
   assign cnt_min_tick = (cnt_q == '0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic obs_t mk(input logic clr, input logic ld, input logic en,
                               input logic up, input logic bsy, input logic dn,
                               input logic wr, input int d, input int q,
                               input int idx);
      obs_t o;
      o.clr  = clr;
      o.ld   = ld;
      o.en   = en;
      o.up   = up;
      o.busy = bsy;
      o.done = dn;
      o.wr   = wr;
      o.d    = N'(d);
      o.q    = N'(q);
      o.idx  = CW'(idx);
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("clr=%b ld=%b en=%b up=%b busy=%b done=%b wr=%b d=%0d q=%0d idx=%0d",
                       o.clr, o.ld, o.en, o.up, o.busy, o.done, o.wr, o.d, o.q, o.idx);
   endfunction

   // cnt_d is only defined while loading or idle; it is masked elsewhere.
   function automatic obs_t sample();
      obs_t o;
      o.clr  = cnt_syn_clr;
      o.ld   = cnt_load;
      o.en   = cnt_en;
      o.up   = cnt_up;
      o.busy = busy;
      o.done = done;
      o.wr   = wrapped;
      o.d    = (cnt_load || !busy) ? cnt_d : '0;
      o.q    = cnt_q;
      o.idx  = sweep_idx;
      return o;
   endfunction

   // Called at a falling edge with inputs already driven: push the expected
   // outputs, sample 1 ns later, pop and compare, advance to the next falling edge.
   task automatic step(input string tag, input obs_t e);
      obs_t o;
      obs_t x;
      exp_q.push_back(e);
      #1;
      o = sample();
      x = exp_q.pop_front();
      n_tests++;
      assert (o === x) else begin
         n_fail++;
         $error("FAIL %s: observed %s, expected %s", tag, fmt(o), fmt(x));
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      mode = 2'b00; start_val = '0; stop_val = '0; sweeps = '0;
      #2 rst = 1'b0;
      @(negedge clk);

      // Reset state
      step("reset 0", mk(0,0,0,0,0,0,0,0,0,0));
      step("reset 1", mk(0,0,0,0,0,0,0,0,0,0));
      rst = 1'b1;
      step("post-reset idle", mk(0,0,0,0,0,0,0,0,0,0));

      // Up-only 1 -> 5, one sweep
      mode = 2'b00; start_val = 3'd1; stop_val = 3'd5; sweeps = 4'd1; start = 1'b1;
      step("up idle-start", mk(0,0,0,0,0,0,0,0,0,0));
      start = 1'b0;
      step("up load", mk(0,1,0,1,1,0,0,1,0,0));
      for (int i = 1; i <= 4; i++) step("up run", mk(0,0,1,1,1,0,0,0,i,0));
      step("up reach stop", mk(0,0,0,1,1,0,0,0,5,0));
      step("up done", mk(0,0,0,1,1,1,0,0,5,0));
      step("up idle", mk(0,0,0,0,0,0,0,0,5,0));

      // Ping-pong 2 <-> 6, three sweeps, single load
      mode = 2'b10; start_val = 3'd2; stop_val = 3'd6; sweeps = 4'd3; start = 1'b1;
      step("pp idle-start", mk(0,0,0,0,0,0,0,0,5,0));
      start = 1'b0;
      step("pp load", mk(0,1,0,1,1,0,0,2,5,0));
      for (int i = 2; i <= 5; i++) step("pp sweep0", mk(0,0,1,1,1,0,0,0,i,0));
      step("pp sweep0 end", mk(0,0,0,1,1,0,0,0,6,0));
      step("pp turn0", mk(0,0,0,1,1,0,0,0,6,0));
      for (int i = 6; i >= 3; i--) step("pp sweep1", mk(0,0,1,0,1,0,0,0,i,1));
      step("pp sweep1 end", mk(0,0,0,0,1,0,0,0,2,1));
      step("pp turn1", mk(0,0,0,0,1,0,0,0,2,1));
      for (int i = 2; i <= 5; i++) step("pp sweep2", mk(0,0,1,1,1,0,0,0,i,2));
      step("pp sweep2 end", mk(0,0,0,1,1,0,0,0,6,2));
      step("pp done", mk(0,0,0,1,1,1,0,0,6,2));
      step("pp idle holds idx", mk(0,0,0,0,0,0,0,0,6,2));

      // Up-only through the wrap: 6,7,0,1
      mode = 2'b00; start_val = 3'd6; stop_val = 3'd1; sweeps = 4'd1; start = 1'b1;
      step("wrap idle-start", mk(0,0,0,0,0,0,0,0,6,2));
      start = 1'b0;
      step("wrap load", mk(0,1,0,1,1,0,0,6,6,0));
      step("wrap run q6", mk(0,0,1,1,1,0,0,0,6,0));
      step("wrap run q7", mk(0,0,1,1,1,0,0,0,7,0));
      step("wrap run q0", mk(0,0,1,1,1,0,1,0,0,0));
      step("wrap reach stop", mk(0,0,0,1,1,0,1,0,1,0));
      step("wrap done", mk(0,0,0,1,1,1,1,0,1,0));
      step("wrap idle sticky", mk(0,0,0,0,0,0,1,0,1,0));

      // Down-only 4 -> 1, two sweeps, pause mid-sweep and during TURN
      mode = 2'b01; start_val = 3'd4; stop_val = 3'd1; sweeps = 4'd2; start = 1'b1;
      step("dn idle-start", mk(0,0,0,0,0,0,1,0,1,0));
      start = 1'b0;
      step("dn load0", mk(0,1,0,0,1,0,0,4,1,0));
      step("dn run q4", mk(0,0,1,0,1,0,0,0,4,0));
      pause = 1'b1;
      for (int i = 0; i < 3; i++) step("dn paused", mk(0,0,0,0,1,0,0,0,3,0));
      pause = 1'b0;
      step("dn run q3", mk(0,0,1,0,1,0,0,0,3,0));
      step("dn run q2", mk(0,0,1,0,1,0,0,0,2,0));
      step("dn sweep0 end", mk(0,0,0,0,1,0,0,0,1,0));
      pause = 1'b1;
      step("dn turn paused", mk(0,0,0,0,1,0,0,0,1,0));
      pause = 1'b0;
      step("dn load1", mk(0,1,0,0,1,0,0,4,1,1));
      for (int i = 4; i >= 2; i--) step("dn sweep1", mk(0,0,1,0,1,0,0,0,i,1));
      step("dn sweep1 end", mk(0,0,0,0,1,0,0,0,1,1));
      step("dn done", mk(0,0,0,0,1,1,0,0,1,1));
      step("dn idle", mk(0,0,0,0,0,0,0,0,1,1));

      // Abort at q=3 with a start pulse issued while busy
      mode = 2'b00; start_val = 3'd1; stop_val = 3'd5; sweeps = 4'd1; start = 1'b1;
      step("ab idle-start", mk(0,0,0,0,0,0,0,0,1,1));
      start = 1'b0;
      step("ab load", mk(0,1,0,1,1,0,0,1,1,0));
      start = 1'b1; mode = 2'b01; start_val = 3'd0; stop_val = 3'd7; sweeps = 4'd5;
      step("ab start ignored", mk(0,0,1,1,1,0,0,0,1,0));
      start = 1'b0;
      step("ab run q2", mk(0,0,1,1,1,0,0,0,2,0));
      abort = 1'b1;
      step("ab run q3", mk(0,0,1,1,1,0,0,0,3,0));
      abort = 1'b0;
      step("ab idle syn_clr", mk(1,0,0,0,0,0,0,0,4,0));
      step("ab idle cleared", mk(0,0,0,0,0,0,0,0,0,0));

      // Asynchronous reset in the middle of RUN
      mode = 2'b00; start_val = 3'd0; stop_val = 3'd5; sweeps = 4'd1; start = 1'b1;
      step("rs idle-start", mk(0,0,0,0,0,0,0,0,0,0));
      start = 1'b0;
      step("rs load", mk(0,1,0,1,1,0,0,0,0,0));
      step("rs run q0", mk(0,0,1,1,1,0,0,0,0,0));
      step("rs run q1", mk(0,0,1,1,1,0,0,0,1,0));
      rst = 1'b0;
      step("rs async reset", mk(0,0,0,0,0,0,0,0,0,0));
      rst = 1'b1;

      // Abort in IDLE is ignored; start+abort together takes start
      abort = 1'b1;
      step("idle abort ignored", mk(0,0,0,0,0,0,0,0,0,0));
      mode = 2'b11; start_val = 3'd3; stop_val = 3'd3; sweeps = 4'd0; start = 1'b1;
      step("zl idle-start+abort", mk(0,0,0,0,0,0,0,0,0,0));
      start = 1'b0; abort = 1'b0;
      // Zero-length sweep, sweeps=0 behaves as 1, reserved mode behaves as up
      step("zl load", mk(0,1,0,1,1,0,0,3,0,0));
      step("zl run no en", mk(0,0,0,1,1,0,0,0,3,0));
      step("zl done", mk(0,0,0,1,1,1,0,0,3,0));
      step("zl idle", mk(0,0,0,0,0,0,0,0,3,0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
